sobel_stream_out: RTL and testbench
===================================

Name: sobel_stream_out

Overview:
- Downstream stage of the Sobel convolution output (convolved pixel + valid), which has no backpressure.
- Buffers convolved pixels in a small FIFO and presents them to the DMA as an AXI-Stream master.
- Generates TLAST on the final pixel of each frame, flags overflow, and raises a stall hint for the line-buffer controller.

Parameters:
- FRAME_PIXELS, 260100, output beats per frame ((510*510) for a 512x512 input); TLAST asserted on beat FRAME_PIXELS-1.
- DEPTH, 16, FIFO entries; power of two, at least 4.
- MARGIN, 4, free-slot threshold below which Ready_out deasserts; covers the upstream pipeline latency.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous active-high reset.
- Valid_in  input  1  convolved pixel valid, from the convolution stage.
- Data_in  input  8  convolved pixel.
- Ready_out  output  1  stall hint to upstream; high when free slots > MARGIN.
- M_Valid  output  1  AXI-Stream TVALID to DMA.
- M_Data  output  8  AXI-Stream TDATA.
- M_Last  output  1  AXI-Stream TLAST.
- M_Ready  input  1  AXI-Stream TREADY from DMA.
- Frame_done  output  1  one-cycle pulse after the TLAST beat handshakes.
- Overflow  output  1  sticky; a pixel was dropped because the FIFO was full.

Behaviour:
- One clock, Clk. Reset is synchronous, active-high (Rst), sampled on the rising edge.
- Reset values:
  - M_Valid=0, M_Data=0, M_Last=0.
  - Frame_done=0, Overflow=0, Ready_out=1.
  - FIFO empty, beat counter=0.
- Storage: circular buffer of DEPTH x 8.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
- Write: when Valid_in=1 and (count<DEPTH, or a read handshake occurs the same cycle).
  - The pixel is stored; Valid_in is never stalled.
- Overflow: Valid_in=1 with count=DEPTH and no read that cycle.
  - Pixel is dropped, Overflow sets and stays 1 until Rst; pointers unchanged.
- Read handshake: M_Valid & M_Ready in the same cycle.
  - Read pointer advances and the beat counter increments.
- Output register: first-word-fall-through.
  - M_Valid=1 whenever count>0; M_Data equals the head entry.
  - Latency from write into an empty FIFO to M_Valid=1 is 1 cycle.
- AXI rules:
  - Once M_Valid=1, M_Data and M_Last stay stable until the handshake.
  - M_Valid never drops without a handshake, except on Rst.
- Simultaneous read and write: count unchanged. At count=DEPTH the write is accepted (no overflow); at count=0 there is no read, since M_Valid=0.
- M_Last = M_Valid and (beat counter == FRAME_PIXELS-1).
- Beat counter: on the TLAST handshake it wraps to 0 and Frame_done pulses high for exactly the next cycle. Dropped pixels are not counted, so TLAST stays aligned to delivered beats.
- Ready_out = (DEPTH - count) > MARGIN, driven combinationally from the registered count.
- M_Ready=0 for many cycles: data is held; the FIFO fills; Ready_out falls at count=DEPTH-MARGIN; overflow occurs only if upstream ignores Ready_out.
- Rst mid-frame: FIFO flushed, counter cleared, Overflow cleared, any in-flight beat abandoned. The next accepted beat is beat 0 of a new frame.

Test Plan (FRAME_PIXELS=8, DEPTH=4, MARGIN=1 unless noted):
- Reset: hold Rst for 2 cycles with Valid_in=1 -> M_Valid=0, Ready_out=1, Overflow=0, nothing stored.
- Streaming: M_Ready=1, write Data_in=0x10..0x17 on 8 consecutive cycles -> M_Data 0x10..0x17 each 1 cycle after its write; M_Last=1 only on 0x17; Frame_done pulses the cycle after.
- Backpressure: M_Ready=0, write 0xA0,0xA1,0xA2 -> Ready_out=0 after the 3rd write (free=1); M_Data stays 0xA0 while M_Valid=1; after M_Ready=1, 0xA0,0xA1,0xA2 are delivered in order.
- Overflow: M_Ready=0, write 0x01..0x05 -> first 4 stored, 0x05 dropped, Overflow=1 and sticky; release M_Ready -> 0x01..0x04 delivered.
- Full with simultaneous read: FIFO full with M_Ready=1 and Valid_in=1 -> one beat out, one beat in; count stays 4; Overflow stays 0.
- Mid-frame reset: after 5 beats, pulse Rst, then send 8 beats -> M_Last on the 8th post-reset beat, not the 3rd.

Source files
------------

// File: rtl/sobel_stream_out.sv
// sobel_stream_out: buffers convolved Sobel pixels (no upstream backpressure)
// in a small circular FIFO and presents them as an AXI-Stream master with
// TLAST on the final beat of each frame, a sticky overflow flag, a
// frame-done pulse and a stall hint for the line-buffer controller.
module sobel_stream_out #(
    parameter int FRAME_PIXELS = 260100,
    parameter int DEPTH        = 16,
    parameter int MARGIN       = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Valid_in,
    input  logic [7:0] Data_in,
    output logic       Ready_out,
    output logic       M_Valid,
    output logic [7:0] M_Data,
    output logic       M_Last,
    input  logic       M_Ready,
    output logic       Frame_done,
    output logic       Overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C  = CW'(MARGIN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_PIXELS - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;

    logic          rd_hs_s;
    logic          full_s;
    logic          wr_en_s;
    logic          drop_s;

    // Next-state logic: handshake/write decisions, pointers, occupancy,
    // beat counter and the look-ahead values of the registered outputs.
    always_comb begin
        rd_hs_s = valid_q & M_Ready;
        full_s  = (count_q == DEPTH_C);
        // A full FIFO still accepts a pixel when a beat leaves the same cycle.
        wr_en_s = Valid_in & (~full_s | rd_hs_s);
        drop_s  = Valid_in & full_s & ~rd_hs_s;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_hs_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_hs_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Only delivered beats advance the counter, so dropped pixels never
        // shift TLAST.
        if (rd_hs_s) begin
            if (beat_q == LAST_BEAT) begin
                beat_d = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end else begin
            beat_d = beat_q;
        end

        valid_d = (count_d != '0);

        // Head entry after this cycle; bypass the array when the incoming
        // pixel lands directly at the new head (FIFO empty or draining).
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            data_d = Data_in;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end

        last_d = valid_d & (beat_d == LAST_BEAT);
        done_d = rd_hs_s & last_q;
        ovf_d  = ovf_q | drop_s;
    end

    // State and registered outputs, with synchronous reset flushing the FIFO.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            last_q   <= last_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    // Pixel storage array; contents are meaningless outside the occupied
    // window, so it is written without reset.
    always_ff @(posedge Clk) begin
        if (wr_en_s && !Rst) begin
            mem_q[wr_ptr_q] <= Data_in;
        end
    end

    // Stall hint from the registered occupancy so it never depends on the
    // downstream ready in the same cycle.
    always_comb begin
        Ready_out = ((DEPTH_C - count_q) > MARGIN_C);
    end

    assign M_Valid    = valid_q;
    assign M_Data     = data_q;
    assign M_Last     = last_q;
    assign Frame_done = done_q;
    assign Overflow   = ovf_q;

endmodule

// File: tb/tb_sobel_stream_out.sv
// Directed self-checking bench for sobel_stream_out with a small frame
// (8 beats), a 4-entry FIFO and a margin of 1.
module tb_sobel_stream_out;

    logic       Clk;
    logic       Rst;
    logic       Valid_in;
    logic [7:0] Data_in;
    logic       Ready_out;
    logic       M_Valid;
    logic [7:0] M_Data;
    logic       M_Last;
    logic       M_Ready;
    logic       Frame_done;
    logic       Overflow;

    int errors;
    int checks;

    sobel_stream_out #(
        .FRAME_PIXELS(8),
        .DEPTH       (4),
        .MARGIN      (1)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Valid_in  (Valid_in),
        .Data_in   (Data_in),
        .Ready_out (Ready_out),
        .M_Valid   (M_Valid),
        .M_Data    (M_Data),
        .M_Last    (M_Last),
        .M_Ready   (M_Ready),
        .Frame_done(Frame_done),
        .Overflow  (Overflow)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        Rst      = 1'b1;
        Valid_in = 1'b1;
        Data_in  = 8'h55;
        M_Ready  = 1'b0;

        // ---- Reset with Valid_in held high ----
        tick();
        tick();
        Rst      = 1'b0;
        Valid_in = 1'b0;
        check("rst_valid",  M_Valid,    1'b0);
        check("rst_data",   M_Data,     8'h00);
        check("rst_last",   M_Last,     1'b0);
        check("rst_ready",  Ready_out,  1'b1);
        check("rst_ovf",    Overflow,   1'b0);
        check("rst_done",   Frame_done, 1'b0);
        tick();
        check("rst_empty",  M_Valid,    1'b0);

        // ---- Streaming a full frame with M_Ready=1 ----
        M_Ready  = 1'b1;
        Valid_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            Data_in = 8'h10 + 8'(k);
            tick();
            if (k == 7) Valid_in = 1'b0;
            check("str_valid", M_Valid, 1'b1);
            check("str_data",  M_Data,  32'h10 + 32'(k));
            check("str_last",  M_Last,  (k == 7) ? 1'b1 : 1'b0);
            check("str_done",  Frame_done, 1'b0);
        end
        tick();
        check("str_done_pulse", Frame_done, 1'b1);
        check("str_empty",      M_Valid,    1'b0);
        tick();
        check("str_done_clear", Frame_done, 1'b0);

        // ---- Backpressure: 3 writes with M_Ready=0 ----
        M_Ready  = 1'b0;
        Valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            Data_in = 8'hA0 + 8'(k);
            tick();
            check("bp_valid", M_Valid,   1'b1);
            check("bp_hold",  M_Data,    8'hA0);
            check("bp_ready", Ready_out, (k == 2) ? 1'b0 : 1'b1);
        end
        Valid_in = 1'b0;
        tick();
        check("bp_hold2", M_Data, 8'hA0);
        M_Ready = 1'b1;
        for (int k = 1; k < 3; k++) begin
            tick();
            check("bp_drain_v", M_Valid, 1'b1);
            check("bp_drain_d", M_Data,  32'hA0 + 32'(k));
            check("bp_drain_l", M_Last,  1'b0);
        end
        tick();
        check("bp_empty", M_Valid,   1'b0);
        check("bp_ready_back", Ready_out, 1'b1);

        // ---- Overflow: 5 writes into a 4-entry FIFO ----
        // Beat counter now at 3 (A0..A2 were beats 0..2).
        M_Ready  = 1'b0;
        Valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            Data_in = 8'h01 + 8'(k);
            tick();
            check("ovf_flag", Overflow, (k == 4) ? 1'b1 : 1'b0);
            check("ovf_head", M_Data,   8'h01);
        end
        Valid_in = 1'b0;
        M_Ready  = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("ovf_drain_d", M_Data,   32'h01 + 32'(k));
            check("ovf_sticky",  Overflow, 1'b1);
            check("ovf_last",    M_Last,   1'b0);
        end
        tick();
        check("ovf_drop", M_Valid,  1'b0);
        check("ovf_keep", Overflow, 1'b1);

        // ---- Full FIFO with simultaneous read and write ----
        do_reset();
        check("rst2_ovf", Overflow, 1'b0);
        M_Ready  = 1'b0;
        Valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            Data_in = 8'hB0 + 8'(k);
            tick();
        end
        check("full_head",  M_Data,    8'hB0);
        check("full_ready", Ready_out, 1'b0);
        Data_in = 8'hB4;
        M_Ready = 1'b1;
        tick();
        Valid_in = 1'b0;
        check("rw_head",  M_Data,    8'hB1);
        check("rw_ovf",   Overflow,  1'b0);
        check("rw_ready", Ready_out, 1'b0);
        for (int k = 2; k < 5; k++) begin
            tick();
            check("rw_drain_v", M_Valid, 1'b1);
            check("rw_drain_d", M_Data,  32'hB0 + 32'(k));
        end
        tick();
        check("rw_count4", M_Valid,  1'b0);
        check("rw_ovf2",   Overflow, 1'b0);

        // ---- Mid-frame reset after 5 delivered beats (B0..B4) ----
        do_reset();
        check("mid_rst_valid", M_Valid, 1'b0);
        M_Ready  = 1'b1;
        Valid_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            Data_in = 8'hC0 + 8'(k);
            tick();
            if (k == 7) Valid_in = 1'b0;
            check("mid_data", M_Data, 32'hC0 + 32'(k));
            check("mid_last", M_Last, (k == 7) ? 1'b1 : 1'b0);
        end
        tick();
        check("mid_done", Frame_done, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
